// File: rtl/rx_seq_pkg.sv
// Shared types and widths for the RX DDR ring sequencer.
package rx_seq_pkg;
    localparam int ADDR_W = 48;
    localparam int CNT_W  = 32;
    localparam int LEN_W  = 17;

    typedef logic [LEN_W-1:0] packet_len_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_READ = 3'd2,
        ST_TSET = 3'd3,
        ST_TCLR = 3'd4,
        ST_STOP = 3'd5
    } seq_state_e;
endpackage

// File: rtl/rx_seq_ring_ptr.sv
// Ring read-offset register: clears to zero on load, advances by one packet with wrap at ring size.
module rx_seq_ring_ptr
    import rx_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_zero,
    input  logic             advance,
    input  packet_len_t      len,
    input  logic [CNT_W-1:0] size,
    output logic [CNT_W-1:0] offset
);
    logic [CNT_W-1:0] offset_q, offset_d;
    logic [CNT_W:0]   sum;
    logic [CNT_W:0]   wrapped;

    // One extra bit so offset + len cannot overflow before the compare against size.
    always_comb begin
        sum      = {1'b0, offset_q} + {{(CNT_W + 1 - LEN_W){1'b0}}, len};
        wrapped  = sum - {1'b0, size};
        offset_d = offset_q;
        if (load_zero) begin
            offset_d = '0;
        end else if (advance) begin
            offset_d = (sum >= {1'b0, size}) ? wrapped[CNT_W-1:0] : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
        end
    end

    assign offset = offset_q;
endmodule

// File: rtl/rx_dma_sequencer.sv
// RX DDR ring sequencer: enables the write DMA, issues USB reads per packet, retires packets via tick/ack.
// Optional build macro RX_SEQ_OVF_HALT_EN adds the ovf_halted port and halts the run on RX overflow.
module rx_dma_sequencer
    import rx_seq_pkg::*;
(
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic [ADDR_W-1:0] buffer_base_address,
    input  logic [CNT_W-1:0]  buffer_size,
    input  logic [LEN_W-1:0]  packet_size_bytes,
    input  logic [CNT_W-1:0]  packet_count_set,
    output logic              write_enable,
    input  logic              buffer_empty,
    input  logic              buffer_overflow,
    output logic              buffer_packet_tick,
    input  logic              buffer_packet_tick_ack,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [LEN_W-1:0]  rd_len_bytes,
    input  logic              rd_done,
    input  logic              rd_error,
    output logic              seq_busy,
    output logic [2:0]        seq_state,
`ifdef RX_SEQ_OVF_HALT_EN
    output logic              ovf_halted,
`endif
    output logic [CNT_W-1:0]  packets_done,
    output logic [CNT_W-1:0]  rd_offset,
    output logic              seq_error
);
    seq_state_e        state_q, state_d;
    logic              write_enable_q, write_enable_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              tick_q, tick_d;
    logic [CNT_W-1:0]  packets_done_q, packets_done_d;
    logic              seq_error_q, seq_error_d;
    logic              stop_pending_q, stop_pending_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  size_q, size_d;
    packet_len_t       len_q, len_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    logic              halt_req;
    logic              stop_now;
    logic              ring_load;
    logic              ring_adv;
    logic [CNT_W-1:0]  pkt_inc;

`ifdef RX_SEQ_OVF_HALT_EN
    // Overflow only latches while the ring is being consumed; the halt then behaves like a stop.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == ST_IDLE && cmd_start && !cmd_stop) begin
            ovf_d = 1'b0;
        end else if (buffer_overflow && (state_q == ST_WAIT || state_q == ST_READ)) begin
            ovf_d = 1'b1;
        end
        halt_req = ovf_d;
    end
    assign ovf_halted = ovf_q;
`else
    logic ovf_unused;
    assign ovf_unused = buffer_overflow;
    assign ovf_d      = 1'b0;
    assign halt_req   = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        write_enable_d = write_enable_q;
        rd_req_d       = rd_req_q;
        rd_addr_d      = rd_addr_q;
        tick_d         = tick_q;
        packets_done_d = packets_done_q;
        seq_error_d    = seq_error_q;
        stop_pending_d = stop_pending_q;
        base_d         = base_q;
        size_d         = size_q;
        len_d          = len_q;
        count_d        = count_q;
        ring_load      = 1'b0;
        ring_adv       = 1'b0;
        pkt_inc        = packets_done_q + 1'b1;
        stop_now       = stop_pending_q | cmd_stop | halt_req;

        if (state_q != ST_IDLE && cmd_stop) begin
            stop_pending_d = 1'b1;
            write_enable_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_start && !cmd_stop) begin
                    base_d         = buffer_base_address;
                    size_d         = buffer_size;
                    len_d          = packet_size_bytes;
                    count_d        = packet_count_set;
                    packets_done_d = '0;
                    seq_error_d    = 1'b0;
                    ring_load      = 1'b1;
                    write_enable_d = 1'b1;
                    state_d        = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (stop_now) begin
                    state_d = ST_STOP;
                end else if (!buffer_empty) begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = base_q + {{(ADDR_W - CNT_W){1'b0}}, rd_offset};
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                if (rd_done) begin
                    rd_req_d = 1'b0;
                    if (rd_error) begin
                        seq_error_d = 1'b1;
                        state_d     = ST_STOP;
                    end else begin
                        tick_d  = 1'b1;
                        state_d = ST_TSET;
                    end
                end
            end
            ST_TSET: begin
                if (buffer_packet_tick_ack) begin
                    tick_d  = 1'b0;
                    state_d = ST_TCLR;
                end
            end
            ST_TCLR: begin
                // The packet is only retired once the ack has fully returned low.
                if (!buffer_packet_tick_ack) begin
                    packets_done_d = pkt_inc;
                    ring_adv       = 1'b1;
                    if ((count_q != '0 && pkt_inc == count_q) || stop_now) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_STOP: begin
                write_enable_d = 1'b0;
                stop_pending_d = 1'b0;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q        <= ST_IDLE;
            write_enable_q <= 1'b0;
            rd_req_q       <= 1'b0;
            rd_addr_q      <= '0;
            tick_q         <= 1'b0;
            packets_done_q <= '0;
            seq_error_q    <= 1'b0;
            stop_pending_q <= 1'b0;
            base_q         <= '0;
            size_q         <= '0;
            len_q          <= '0;
            count_q        <= '0;
            ovf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            write_enable_q <= write_enable_d;
            rd_req_q       <= rd_req_d;
            rd_addr_q      <= rd_addr_d;
            tick_q         <= tick_d;
            packets_done_q <= packets_done_d;
            seq_error_q    <= seq_error_d;
            stop_pending_q <= stop_pending_d;
            base_q         <= base_d;
            size_q         <= size_d;
            len_q          <= len_d;
            count_q        <= count_d;
            ovf_q          <= ovf_d;
        end
    end

    rx_seq_ring_ptr u_ring_ptr (
        .clk       (aclk),
        .rst_n     (aresetn),
        .load_zero (ring_load),
        .advance   (ring_adv),
        .len       (len_q),
        .size      (size_q),
        .offset    (rd_offset)
    );

    assign write_enable       = write_enable_q;
    assign rd_req             = rd_req_q;
    assign rd_addr            = rd_addr_q;
    assign rd_len_bytes       = len_q;
    assign buffer_packet_tick = tick_q;
    assign packets_done       = packets_done_q;
    assign seq_error          = seq_error_q;
    assign seq_busy           = (state_q != ST_IDLE);
    assign seq_state          = state_q;
endmodule
